// File: rtl/credit_resp_buffer_mem.sv
// Response storage for credit_resp_buffer: Depth entries of dtype.
// Synchronous write with enable, asynchronous read by index. Contents are not reset.
module credit_resp_buffer_mem #(
    parameter int unsigned Depth    = 4,
    parameter type         dtype    = logic,
    parameter int unsigned PtrWidth = 2
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [PtrWidth-1:0] waddr_i,
    input  dtype                wdata_i,
    input  logic [PtrWidth-1:0] raddr_i,
    output dtype                rdata_o
);

    dtype mem_q [Depth];

    // Write port: the enable is the push strobe alone, so gating can be inserted cleanly.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/credit_resp_buffer.sv
// Credit-metered response buffer behind a fixed-latency, non-stallable delay line.
// Every issued request reserves one buffer entry, so a response always has a slot,
// and the consumer is free to stall.
module credit_resp_buffer #(
    parameter int unsigned    Depth    = 4,
    parameter type            dtype    = logic,
    localparam int unsigned   CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    output logic                issue_fire_o,
    input  logic                resp_valid_i,
    input  dtype                resp_data_i,
    output logic                data_valid_o,
    input  logic                data_ready_i,
    output dtype                data_o,
    output logic [CntWidth-1:0] credits_o,
    output logic                err_o
);

    // With a single entry the pointers never move; keep them one bit wide and pinned at 0.
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    if (Depth < 1) begin : g_bad_depth
        $fatal(1, "credit_resp_buffer: Depth must be at least 1");
    end

    logic [CntWidth-1:0] inflight_q, inflight_d;
    logic [CntWidth-1:0] usage_q,    usage_d;
    logic [PtrWidth-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q,   rd_ptr_d;
    logic                err_q,      err_d;

    logic push;
    logic pop;
    logic orphan;

    assign credits_o     = CntWidth'(Depth) - inflight_q - usage_q;
    assign issue_ready_o = (credits_o != '0);
    assign issue_fire_o  = issue_valid_i & issue_ready_o;

    // A response counts only if something is in flight; otherwise it is an orphan and dropped.
    assign push   = resp_valid_i & (inflight_q != '0);
    assign orphan = resp_valid_i & (inflight_q == '0);

    assign data_valid_o = (usage_q != '0);
    assign pop          = data_valid_o & data_ready_i;
    assign err_o        = err_q;

    credit_resp_buffer_mem #(
        .Depth    (Depth),
        .dtype    (dtype),
        .PtrWidth (PtrWidth)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (resp_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_o)
    );

    // Next-state for counters, wrapping pointers and the sticky orphan flag.
    always_comb begin
        inflight_d = inflight_q + CntWidth'(issue_fire_o) - CntWidth'(push);
        usage_d    = usage_q + CntWidth'(push) - CntWidth'(pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q | orphan;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
        end
    end

    // State registers; reset discards anything buffered or in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inflight_q <= '0;
            usage_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            usage_q    <= usage_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    // Credit invariant: reserved plus occupied entries never exceed the buffer.
    a_credit_invariant : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ({1'b0, inflight_q} + {1'b0, usage_q}) <= (CntWidth + 1)'(Depth));

    // A push into a full buffer is only legal alongside a pop.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (usage_q == CntWidth'(Depth))));

endmodule

// File: tb/tb_credit_resp_buffer.sv
// Directed bench for credit_resp_buffer: Depth=4, 8-bit payload, 3-cycle delay line model.
module tb_credit_resp_buffer;

    logic       clk;
    logic       rst_n;
    logic       issue_valid;
    logic       issue_ready;
    logic       issue_fire;
    logic [7:0] issue_data;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] data_out;
    logic [2:0] credits;
    logic       err;

    logic       inj_valid;
    logic [7:0] inj_data;
    logic [2:0] dl_v;
    logic [7:0] dl_d [3];

    int n_checks;
    int n_errors;
    int sent;

    credit_resp_buffer #(
        .Depth (4),
        .dtype (logic [7:0])
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_fire_o  (issue_fire),
        .resp_valid_i  (resp_valid),
        .resp_data_i   (resp_data),
        .data_valid_o  (data_valid),
        .data_ready_i  (data_ready),
        .data_o        (data_out),
        .credits_o     (credits),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed 3-cycle delay line, reset together with the DUT.
    always @(posedge clk) begin
        if (!rst_n) begin
            dl_v <= '0;
        end else begin
            dl_v    <= {dl_v[1:0], issue_fire};
            dl_d[0] <= issue_data;
            dl_d[1] <= dl_d[0];
            dl_d[2] <= dl_d[1];
        end
    end

    assign resp_valid = dl_v[2] | inj_valid;
    assign resp_data  = inj_valid ? inj_data : dl_d[2];

    // One line per transaction on either side.
    always @(negedge clk) begin
        if (rst_n && issue_fire) $display("issue  data=%02h", issue_data);
        if (rst_n && data_valid && data_ready) $display("pop    data=%02h", data_out);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_q [4];
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_data  = 8'h00;
        data_ready  = 1'b0;
        inj_valid   = 1'b0;
        inj_data    = 8'h00;

        // Reset and idle.
        step(); step();
        rst_n = 1'b1;
        step(); #1;
        check("rst_credits", 32'(credits), 32'd4);
        check("rst_ready",   32'(issue_ready), 32'd1);
        check("rst_valid",   32'(data_valid), 32'd0);
        check("rst_err",     32'(err), 32'd0);

        // Single request, consumer always ready: data at cycle 4, credits back at cycle 5.
        issue_valid = 1'b1;
        issue_data  = 8'h11;
        data_ready  = 1'b1;
        #1;
        check("single_fire",  32'(issue_fire), 32'd1);
        check("single_cred0", 32'(credits), 32'd4);
        for (int c = 1; c <= 5; c++) begin
            step();
            issue_valid = 1'b0;
            #1;
            check($sformatf("single_cred_c%0d", c), 32'(credits), (c <= 4) ? 32'd3 : 32'd4);
            check($sformatf("single_valid_c%0d", c), 32'(data_valid), (c == 4) ? 32'd1 : 32'd0);
            if (c == 4) check("single_data", 32'(data_out), 32'h11);
        end

        // Consumer stalled, six back-to-back attempts: only four may launch.
        data_ready = 1'b0;
        sent = 0;
        for (int k = 0; k < 10; k++) begin
            issue_valid = (sent < 6);
            issue_data  = 8'hA0 + 8'(sent);
            #1;
            if (issue_fire) sent++;
            step();
        end
        #1;
        check("full_fires",   32'(sent), 32'd4);
        check("full_credits", 32'(credits), 32'd0);
        check("full_ready",   32'(issue_ready), 32'd0);
        check("full_valid",   32'(data_valid), 32'd1);
        check("full_head",    32'(data_out), 32'hA0);
        check("full_err",     32'(err), 32'd0);

        // One-cycle pop from full while the request stays asserted: one pop, then one re-issue.
        issue_valid = 1'b1;
        issue_data  = 8'hA4;
        data_ready  = 1'b1;
        #1;
        check("refill_pop_data", 32'(data_out), 32'hA0);
        check("refill_nofire",   32'(issue_fire), 32'd0);
        step();
        data_ready = 1'b0;
        #1;
        check("refill_fire",   32'(issue_fire), 32'd1);
        check("refill_head",   32'(data_out), 32'hA1);
        check("refill_credit", 32'(credits), 32'd1);
        step();
        issue_data = 8'hA5;
        #1;
        check("refill_cred0",   32'(credits), 32'd0);
        check("refill_nofire2", 32'(issue_fire), 32'd0);
        for (int k = 0; k < 4; k++) step();
        issue_valid = 1'b0;
        #1;
        check("refill_full", 32'(credits), 32'd0);

        // Drain: order preserved across the pointer wrap.
        exp_q[0] = 8'hA1;
        exp_q[1] = 8'hA2;
        exp_q[2] = 8'hA3;
        exp_q[3] = 8'hA4;
        data_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("drain_valid_%0d", k), 32'(data_valid), 32'd1);
            check($sformatf("drain_data_%0d", k), 32'(data_out), 32'(exp_q[k]));
            step();
        end
        #1;
        check("drain_empty",   32'(data_valid), 32'd0);
        check("drain_credits", 32'(credits), 32'd4);

        // Orphan response: dropped, sticky error, counters untouched.
        data_ready = 1'b0;
        inj_valid  = 1'b1;
        inj_data   = 8'h5A;
        step();
        inj_valid = 1'b0;
        #1;
        check("orphan_err",     32'(err), 32'd1);
        check("orphan_valid",   32'(data_valid), 32'd0);
        check("orphan_credits", 32'(credits), 32'd4);
        step(); step();
        check("orphan_err_sticky", 32'(err), 32'd1);
        check("orphan_valid2",     32'(data_valid), 32'd0);

        // Reset mid-operation with two buffered and two in flight.
        for (int k = 0; k < 5; k++) begin
            issue_valid = (k < 4);
            issue_data  = 8'hC0 + 8'(k);
            step();
        end
        issue_valid = 1'b0;
        #1;
        check("pre_rst_credits", 32'(credits), 32'd0);
        check("pre_rst_valid",   32'(data_valid), 32'd1);
        check("pre_rst_head",    32'(data_out), 32'hC0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_credits", 32'(credits), 32'd4);
        check("post_rst_valid",   32'(data_valid), 32'd0);
        check("post_rst_err",     32'(err), 32'd0);
        for (int k = 0; k < 4; k++) step();
        check("post_rst_quiet", 32'(data_valid), 32'd0);
        check("post_rst_err2",  32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
